// File: rtl/vga_pkg.sv
// Shared types and default screen geometry for the VGA sprite pipeline.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  typedef logic [2:0] rgb3_t;
  typedef logic [9:0] coord_t;

  typedef enum logic {
    DIR_INC,
    DIR_DEC
  } dir_e;

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of sprite motion: position register plus INC/DEC direction FSM.
// Moves STEP per tick, clamps to [0, MAX] and flags a bounce on the turning tick.
module vga_bounce_axis
  import vga_pkg::*;
#(
  parameter int unsigned MAX  = 608,
  parameter int unsigned STEP = 2
) (
  input  logic   clk,
  input  logic   resetN,
  input  logic   tick,
  output coord_t pos,
  output logic   bounce
);

  localparam logic [10:0] MAX11  = 11'(MAX);
  localparam logic [10:0] STEP11 = 11'(STEP);

  dir_e        state;
  dir_e        stateNext;
  coord_t      posNext;
  logic [10:0] posExt;
  logic [10:0] incSum;
  logic [10:0] decDiff;

  assign posExt  = {1'b0, pos};
  assign incSum  = posExt + STEP11;
  assign decDiff = posExt - STEP11;

  // Direction and position registers; both move only on a frame tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= DIR_INC;
      pos   <= '0;
    end else begin
      state <= stateNext;
      pos   <= posNext;
    end
  end

  // Next position / direction and bounce flag for the current tick.
  always_comb begin
    stateNext = state;
    posNext   = pos;
    bounce    = 1'b0;
    if (tick) begin
      unique case (state)
        DIR_INC: begin
          if (incSum >= MAX11) begin
            posNext   = MAX11[9:0];
            stateNext = DIR_DEC;
            bounce    = 1'b1;
          end else begin
            posNext = incSum[9:0];
          end
        end
        DIR_DEC: begin
          if (posExt <= STEP11) begin
            posNext   = '0;
            stateNext = DIR_INC;
            bounce    = 1'b1;
          end else begin
            posNext = decDiff[9:0];
          end
        end
        default: begin
          stateNext = DIR_INC;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_bouncing_sprite.sv
// Pixel-colour stage: gradient background with a bouncing solid sprite.
// Two-cycle colour pipeline; sync pulses delayed to match.
// Optional feature macro: VGA_SPRITE_BOUNCE_COLOR_EN (sprite colour steps on each bounce).
module vga_bouncing_sprite
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned SPRITE_W = 32,
  parameter int unsigned SPRITE_H = 32,
  parameter int unsigned STEP     = 2
) (
  input  logic   i_clk,
  input  logic   i_resetN,
  input  coord_t i_px,
  input  coord_t i_py,
  input  logic   i_activeArea,
  input  logic   i_hs,
  input  logic   i_vs,
  output logic   o_hs,
  output logic   o_vs,
  output rgb3_t  o_red,
  output rgb3_t  o_green,
  output rgb3_t  o_blue
);

  localparam logic [10:0] SPR_W11 = 11'(SPRITE_W);
  localparam logic [10:0] SPR_H11 = 11'(SPRITE_H);
  localparam coord_t      TICK_Y  = coord_t'(V_ACTIVE);

  logic   tick;
  coord_t sprX;
  coord_t sprY;
  logic   bounceX;
  logic   bounceY;
  logic   hitNow;
  rgb3_t  sprRed;
  rgb3_t  sprGreen;
  rgb3_t  sprBlue;

  logic   s1Hit;
  logic   s1Active;
  rgb3_t  s1PxHi;
  rgb3_t  s1PyHi;
  logic   s1Hs;
  logic   s1Vs;

  assign tick = (i_px == '0) && (i_py == TICK_Y);

  vga_bounce_axis #(
    .MAX (H_ACTIVE - SPRITE_W),
    .STEP(STEP)
  ) axisX (
    .clk   (i_clk),
    .resetN(i_resetN),
    .tick  (tick),
    .pos   (sprX),
    .bounce(bounceX)
  );

  vga_bounce_axis #(
    .MAX (V_ACTIVE - SPRITE_H),
    .STEP(STEP)
  ) axisY (
    .clk   (i_clk),
    .resetN(i_resetN),
    .tick  (tick),
    .pos   (sprY),
    .bounce(bounceY)
  );

  // Sprite rectangle test in 11 bits so sprX+SPRITE_W cannot wrap.
  always_comb begin
    hitNow = i_activeArea
          && ({1'b0, i_px} >= {1'b0, sprX}) && ({1'b0, i_px} < ({1'b0, sprX} + SPR_W11))
          && ({1'b0, i_py} >= {1'b0, sprY}) && ({1'b0, i_py} < ({1'b0, sprY} + SPR_H11));
  end

`ifdef VGA_SPRITE_BOUNCE_COLOR_EN
  rgb3_t colorIdx;

  // Colour index advances once per bouncing tick, cycling 1..7 and never 0.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      colorIdx <= 3'b001;
    end else if (tick && (bounceX || bounceY)) begin
      colorIdx <= (colorIdx == 3'b111) ? 3'b001 : colorIdx + 3'b001;
    end
  end

  // Each index bit drives one full colour channel.
  always_comb begin
    sprRed   = {3{colorIdx[2]}};
    sprGreen = {3{colorIdx[1]}};
    sprBlue  = {3{colorIdx[0]}};
  end
`else
  // Bounce flags have no consumer when the sprite colour is fixed.
  logic unusedBounce;
  assign unusedBounce = bounceX ^ bounceY;

  // Fixed white sprite.
  always_comb begin
    sprRed   = '1;
    sprGreen = '1;
    sprBlue  = '1;
  end
`endif

  // Stage 1: register hit test, active flag, gradient bits and syncs.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      s1Hit    <= '0;
      s1Active <= '0;
      s1PxHi   <= '0;
      s1PyHi   <= '0;
      s1Hs     <= '1;
      s1Vs     <= '1;
    end else begin
      s1Hit    <= hitNow;
      s1Active <= i_activeArea;
      s1PxHi   <= i_px[8:6];
      s1PyHi   <= i_py[8:6];
      s1Hs     <= i_hs;
      s1Vs     <= i_vs;
    end
  end

  // Stage 2: select blank / sprite / gradient colour and output syncs.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
      o_hs    <= '1;
      o_vs    <= '1;
    end else begin
      o_hs <= s1Hs;
      o_vs <= s1Vs;
      if (!s1Active) begin
        o_red   <= '0;
        o_green <= '0;
        o_blue  <= '0;
      end else if (s1Hit) begin
        o_red   <= sprRed;
        o_green <= sprGreen;
        o_blue  <= sprBlue;
      end else begin
        o_red   <= s1PxHi;
        o_green <= s1PyHi;
        o_blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_bouncing_sprite.sv
// Randomized bench for vga_bouncing_sprite against a frame-level sprite model.
// Honours VGA_SPRITE_BOUNCE_COLOR_EN for the expected sprite colour.
module tb_vga_bouncing_sprite;

  localparam int HA   = 640;
  localparam int VA   = 480;
  localparam int SW   = 32;
  localparam int SH   = 32;
  localparam int ST   = 2;
  localparam int MAXX = HA - SW;
  localparam int MAXY = VA - SH;
  localparam logic [10:0] RST_OUT = 11'b000_000_000_11;

  logic       clk = 1'b0;
  logic       resetN;
  logic [9:0] px;
  logic [9:0] py;
  logic       act;
  logic       hs;
  logic       vs;
  logic       hsO;
  logic       vsO;
  logic [2:0] r;
  logic [2:0] g;
  logic [2:0] b;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: position, direction (1 = moving back), colour index.
  int         mx, my;
  bit         mdx, mdy;
  logic [2:0] mc;

  // Expected {r,g,b,hs,vs} for inputs applied one and two cycles ago.
  logic [10:0] h1, h2;

  always #5 clk = ~clk;

  vga_bouncing_sprite #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .SPRITE_W(SW),
    .SPRITE_H(SH),
    .STEP    (ST)
  ) dut (
    .i_clk       (clk),
    .i_resetN    (resetN),
    .i_px        (px),
    .i_py        (py),
    .i_activeArea(act),
    .i_hs        (hs),
    .i_vs        (vs),
    .o_hs        (hsO),
    .o_vs        (vsO),
    .o_red       (r),
    .o_green     (g),
    .o_blue      (b)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    if (obs !== expv) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic modelReset();
    mx  = 0;
    my  = 0;
    mdx = 0;
    mdy = 0;
    mc  = 3'd1;
  endtask

  task automatic stepAxis(inout int pos, inout bit back, input int maxv, output bit bnc);
    bnc = 0;
    if (!back) begin
      if (pos + ST >= maxv) begin
        pos = maxv; back = 1; bnc = 1;
      end else pos = pos + ST;
    end else begin
      if (pos <= ST) begin
        pos = 0; back = 0; bnc = 1;
      end else pos = pos - ST;
    end
  endtask

  task automatic modelTick();
    bit bx, by;
    stepAxis(mx, mdx, MAXX, bx);
    stepAxis(my, mdy, MAXY, by);
    if (bx || by) mc = (mc == 3'd7) ? 3'd1 : mc + 3'd1;
  endtask

  function automatic logic [10:0] expOut(int x, int y, bit a, bit hsi, bit vsi);
    logic [8:0] rgb;
    logic [9:0] xv, yv;
    xv = x[9:0];
    yv = y[9:0];
    if (!a) rgb = '0;
    else if (x >= mx && x < mx + SW && y >= my && y < my + SH) begin
`ifdef VGA_SPRITE_BOUNCE_COLOR_EN
      rgb = {{3{mc[2]}}, {3{mc[1]}}, {3{mc[0]}}};
`else
      rgb = 9'h1ff;
`endif
    end else rgb = {xv[8:6], yv[8:6], 3'b000};
    return {rgb, hsi, vsi};
  endfunction

  // One pixel clock: check outputs due now, then apply new inputs and advance the model.
  task automatic driveCycle(input int x, input int y, input bit a, input bit hsi, input bit vsi);
    @(negedge clk);
    checkVal("rgb", {23'd0, r, g, b}, {23'd0, h2[10:2]});
    checkVal("sync", {30'd0, hsO, vsO}, {30'd0, h2[1:0]});
    h2  = h1;
    px  = x[9:0];
    py  = y[9:0];
    act = a;
    hs  = hsi;
    vs  = vsi;
    h1  = expOut(x, y, a, hsi, vsi);
    if (x == 0 && y == VA) modelTick();
  endtask

  task automatic doReset();
    driveCycle(700, 100, 0, 1, 1);
    #2 resetN = 1'b0;
    #1;
    checkVal("rstRgb", {23'd0, r, g, b}, 32'd0);
    checkVal("rstSync", {30'd0, hsO, vsO}, 32'd3);
    repeat (2) @(negedge clk);
    checkVal("rstHoldRgb", {23'd0, r, g, b}, 32'd0);
    checkVal("rstHoldSync", {30'd0, hsO, vsO}, 32'd3);
    #2 resetN = 1'b1;
    modelReset();
    h1 = RST_OUT;
    h2 = RST_OUT;
  endtask

  task automatic randCycle();
    int sel, x, y, a;
    int offs[8];
    offs = '{-1, 0, 1, SW - 2, SW - 1, SW, SW + 1, 5};
    sel = $urandom_range(0, 99);
    if (sel < 40) begin
      driveCycle(0, VA, 0, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
    end else begin
      if (sel < 75) begin
        x = (mx + offs[$urandom_range(0, 7)]) & 1023;
        y = (my + offs[$urandom_range(0, 7)]) & 1023;
      end else begin
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 524);
      end
      a = (x < HA && y < VA) ? 1 : 0;
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1);
      driveCycle(x, y, a[0], $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
    end
  endtask

  initial begin
    resetN = 1'b1;
    px = 10'd700; py = 10'd100; act = 1'b0; hs = 1'b1; vs = 1'b1;
    #2 resetN = 1'b0;
    #1;
    checkVal("initRgb", {23'd0, r, g, b}, 32'd0);
    checkVal("initSync", {30'd0, hsO, vsO}, 32'd3);
    modelReset();
    h1 = RST_OUT;
    h2 = RST_OUT;
    repeat (2) @(negedge clk);
    #2 resetN = 1'b1;

    // Alignment, motion and boundary probes at the default geometry.
    driveCycle(5, 5, 1, 0, 1);
    driveCycle(700, 100, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      driveCycle(0, VA, 0, 1, 0);
      driveCycle(700, 500, 0, 1, 1);
    end
    driveCycle(6, 6, 1, 1, 1);
    driveCycle(37, 37, 1, 1, 1);
    driveCycle(38, 10, 1, 1, 1);
    driveCycle(5, 6, 1, 1, 1);
    driveCycle(10, 10, 0, 1, 1);
    driveCycle(100, 300, 1, 0, 0);

    for (int i = 0; i < 20000; i++) randCycle();

    // Mid-frame reset with a visible sprite pixel in flight.
    driveCycle(mx + 1, my + 1, 1, 0, 0);
    driveCycle(mx + 2, my + 2, 1, 0, 0);
    doReset();
    driveCycle(1, 1, 1, 1, 1);

    for (int i = 0; i < 25000; i++) randCycle();

    driveCycle(700, 100, 0, 1, 1);
    driveCycle(700, 100, 0, 1, 1);
    driveCycle(700, 100, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/vga_bouncing_sprite.md
# vga_bouncing_sprite

Pixel-colour stage that sits directly downstream of the VGA sync/timing generator, consuming its pixel coordinates, active-area flag and sync pulses. Produces 3-bit-per-channel RGB: a background gradient with a solid rectangular sprite that moves one step per frame and bounces off the screen edges. Sync signals are delayed to stay aligned with the 2-cycle colour pipeline, so outputs connect straight to the VGA pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SPRITE_W, 32, sprite width in pixels (1..H_ACTIVE)
- SPRITE_H, 32, sprite height in lines (1..V_ACTIVE)
- STEP, 2, pixels moved per frame on each axis (≥1)
- i_clk  in  1  pixel clock
- i_resetN  in  1  reset; asynchronous and active-low
- i_px  in  10  horizontal counter from sync generator, includes blanking
- i_py  in  10  vertical counter from sync generator, includes blanking
- i_activeArea  in  1  high while i_px<H_ACTIVE and i_py<V_ACTIVE
- i_hs  in  1  horizontal sync, active-low
- i_vs  in  1  vertical sync, active-low
- o_hs  out  1  i_hs delayed 2 cycles
- o_vs  out  1  i_vs delayed 2 cycles
- o_red, o_green, o_blue  out  3 each  pixel colour

## Operation
- Frame tick: single-cycle pulse when i_px==0 and i_py==V_ACTIVE (first blanking line). Exactly one per frame.
- Position: sprX (10 b), sprY (10 b), top-left corner. Reset: sprX=0, sprY=0.
- Per-axis FSM, states INC / DEC; reset state INC (right / down). Limit MAX = H_ACTIVE-SPRITE_W (x), V_ACTIVE-SPRITE_H (y). On tick:
  - INC: if pos+STEP ≥ MAX → pos=MAX, state→DEC, bounce=1; else pos+=STEP.
  - DEC: if pos ≤ STEP → pos=0, state→INC, bounce=1; else pos-=STEP.
  - No tick: pos and state hold.
- Compare in 11-bit unsigned arithmetic; pos never leaves [0, MAX].
- Stage 1 (registered): hit = i_activeArea && sprX≤i_px<sprX+SPRITE_W && sprY≤i_py<sprY+SPRITE_H; also register active, i_px[8:6], i_py[8:6].
- Stage 2 (registered): if !active → RGB=0; else if hit → sprite colour; else red=px[8:6], green=py[8:6], blue=0.
- Default sprite colour: 7/7/7 (white).

## Timing
- Latency i_px/i_py/i_activeArea → RGB: 2 cycles; i_hs/i_vs → o_hs/o_vs: 2 cycles, same alignment.
- Position/state update occurs in the cycle after the tick, inside vertical blanking; a frame is always rendered with one constant position.
- Reset values: o_red=o_green=o_blue=0, o_hs=1, o_vs=1, all pipeline registers cleared (active=0). Assertion of i_resetN mid-frame forces these immediately; after release, motion resumes from (0,0) at the next tick.
- Both axes bouncing on the same tick (corner) is legal; each axis turns independently.
- Ticks before the first full frame after reset are honoured (no suppression).

## Configuration
- VGA_SPRITE_BOUNCE_COLOR_EN defined: 3-bit colour index c, reset 3'b001; on any tick with a bounce on either axis c increments, skipping 0 (7→1); a corner bounce increments once. Sprite RGB = {3{c[2]}}, {3{c[1]}}, {3{c[0]}}.
- Undefined: no colour register; sprite is fixed white.

## Structure
- Package vga_pkg: H_ACTIVE/V_ACTIVE defaults, typedef rgb3_t (logic [2:0]), enum dir_e {DIR_INC, DIR_DEC}, typedef coord_t (logic [9:0]).
- Sub-module vga_bounce_axis: one axis FSM + position register, parameters MAX and STEP, inputs tick, outputs pos and bounce; instantiated twice.

## Test plan
- Reset: hold i_resetN=0 mid-line → outputs RGB=0, o_hs=o_vs=1 within same cycle; release → sprite at (0,0) in next frame.
- Alignment: i_px=5, i_py=5, active=1 at cycle N → RGB white appears at cycle N+2; i_hs falling at N → o_hs falling at N+2.
- Motion: defaults, after 3 ticks → sprX=6, sprY=6; sprite covers px 6..37, py 6..37; px=38,py=10 → background red=0, green=0, blue=0.
- Right-edge bounce: STEP=2, sprX=606 in INC on tick → sprX=608, DEC; next tick → 606.
- Corner: SPRITE_W=SPRITE_H=32, sprX=606, sprY=446, both INC → both reach MAX and turn; with VGA_SPRITE_BOUNCE_COLOR_EN, c 3'b001→3'b010 (single increment), sprite RGB=0/7/0.
- Blanking: i_activeArea=0 with px/py inside sprite bounds → RGB=0.
